// File: rtl/bce_pred.sv
// ============================================================================
// bce_pred : branch condition evaluation, one-stage result register, 2-bit PHT
// Optional: BCE_PRED_STATS_EN adds br_count / mp_count statistics outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bce_pred #(
  parameter int XLEN      = 32,
  parameter int PHT_DEPTH = 64,
  localparam int IDX_W    = $clog2(PHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [3:0]       bf,
  input  logic             pred_taken,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             stall,
  input  logic             flush,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  output logic             res_valid,
  output logic             taken,
  output logic             mispredict
`ifdef BCE_PRED_STATS_EN
  ,
  output logic [31:0]      br_count,
  output logic [31:0]      mp_count
`endif
);

  localparam logic [1:0] c_ctr_init = 2'b01;
  localparam logic [1:0] c_ctr_max  = 2'b11;
  localparam logic [1:0] c_ctr_min  = 2'b00;

  logic w_eq, w_azero, w_aneg, w_ltu, w_lts;
  logic w_outcome, w_is_branch, w_upd;

  logic             r_valid, r_taken, r_pred, r_br;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_pht [PHT_DEPTH];

  assign w_eq    = (a == b);
  assign w_azero = (a == '0);
  assign w_aneg  = a[XLEN-1];
  assign w_ltu   = (a < b);
  assign w_lts   = ($signed(a) < $signed(b));

  always_comb begin
    w_outcome   = 1'b0;
    w_is_branch = 1'b1;
    case (bf)
      4'b0010:          w_outcome = w_aneg;
      4'b0011:          w_outcome = ~w_aneg;
      4'b1000, 4'b1001: w_outcome = w_eq;
      4'b1010, 4'b1011: w_outcome = ~w_eq;
      4'b1100, 4'b1101: w_outcome = w_aneg | w_azero;
      4'b1110, 4'b1111: w_outcome = ~w_aneg & ~w_azero;
      4'b0100:          w_outcome = w_ltu;
      4'b0101:          w_outcome = ~w_ltu;
      4'b0110:          w_outcome = w_lts;
      4'b0111:          w_outcome = ~w_lts;
      default:          w_is_branch = 1'b0;
    endcase
  end

  // Flush wins over stall: the held result is killed and the new one dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_taken <= 1'b0;
      r_pred  <= 1'b0;
      r_br    <= 1'b0;
      r_idx   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid <= in_valid;
      r_taken <= w_outcome;
      r_pred  <= pred_taken;
      r_br    <= w_is_branch;
      r_idx   <= upd_idx;
    end
  end

  assign res_valid  = r_valid;
  assign taken      = r_taken;
  assign mispredict = r_valid & r_br & (r_taken != r_pred);

  // A stalled result trains the PHT only on the cycle it is released.
  assign w_upd = r_valid & r_br & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= c_ctr_init;
    end else if (w_upd) begin
      if (r_taken && r_pht[r_idx] != c_ctr_max)
        r_pht[r_idx] <= r_pht[r_idx] + 2'd1;
      else if (!r_taken && r_pht[r_idx] != c_ctr_min)
        r_pht[r_idx] <= r_pht[r_idx] - 2'd1;
    end
  end

  // Read returns the pre-update counter on a same-index collision.
  assign lookup_taken = r_pht[lookup_idx][1];

`ifdef BCE_PRED_STATS_EN
  logic [31:0] r_br_count, r_mp_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count <= '0;
      r_mp_count <= '0;
    end else if (w_upd) begin
      r_br_count <= r_br_count + 32'd1;
      if (mispredict) r_mp_count <= r_mp_count + 32'd1;
    end
  end

  assign br_count = r_br_count;
  assign mp_count = r_mp_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bce_pred.sv
// ============================================================================
// tb_bce_pred : directed self-checking bench for bce_pred
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bce_pred;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int IW    = 6;

  logic            clk = 1'b0;
  logic            rst, in_valid, pred_taken, stall, flush;
  logic [XLEN-1:0] a, b;
  logic [3:0]      bf;
  logic [IW-1:0]   upd_idx, lookup_idx;
  logic            lookup_taken, res_valid, taken, mispredict;
`ifdef BCE_PRED_STATS_EN
  logic [31:0]     br_count, mp_count;
`endif

  int n_total = 0;
  int n_pass  = 0;

  bce_pred #(.XLEN(XLEN), .PHT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .bf(bf),
    .pred_taken(pred_taken), .upd_idx(upd_idx), .stall(stall), .flush(flush),
    .lookup_idx(lookup_idx), .lookup_taken(lookup_taken),
    .res_valid(res_valid), .taken(taken), .mispredict(mispredict)
`ifdef BCE_PRED_STATS_EN
    , .br_count(br_count), .mp_count(mp_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vbf,
                       input logic vpred, input logic [IW-1:0] vidx);
    a = va; b = vb; bf = vbf; pred_taken = vpred; upd_idx = vidx; in_valid = 1'b1;
  endtask

  // One isolated branch: capture edge, then resolve/update edge.
  task automatic run_branch(input logic [31:0] va, input logic [31:0] vb, input logic [3:0] vbf,
                            input logic vpred, input logic [IW-1:0] vidx);
    issue(va, vb, vbf, vpred, vidx);
    step();
    in_valid = 1'b0;
    step();
  endtask

  task automatic look(input string tag, input logic [IW-1:0] idx, input logic exp);
    lookup_idx = idx;
    #1;
    check(tag, {31'd0, lookup_taken}, {31'd0, exp});
  endtask

  logic [31:0] ta   [9];
  logic [31:0] tbv  [9];
  logic [3:0]  tbf  [9];
  logic        texp [9];

  initial begin
    ta[0] = 32'h8000_0000; tbv[0] = 32'd0;  tbf[0] = 4'b0010; texp[0] = 1'b1;
    ta[1] = 32'h0000_0000; tbv[1] = 32'd0;  tbf[1] = 4'b0011; texp[1] = 1'b1;
    ta[2] = 32'h0000_0000; tbv[2] = 32'd9;  tbf[2] = 4'b1100; texp[2] = 1'b1;
    ta[3] = 32'h0000_0000; tbv[3] = 32'd0;  tbf[3] = 4'b1110; texp[3] = 1'b0;
    ta[4] = 32'h0000_0001; tbv[4] = 32'd2;  tbf[4] = 4'b1010; texp[4] = 1'b1;
    ta[5] = 32'hFFFF_FFFF; tbv[5] = 32'd1;  tbf[5] = 4'b0111; texp[5] = 1'b0;
    ta[6] = 32'hFFFF_FFFF; tbv[6] = 32'd1;  tbf[6] = 4'b0101; texp[6] = 1'b1;
    ta[7] = 32'h0000_0100; tbv[7] = 32'd0;  tbf[7] = 4'b1111; texp[7] = 1'b1;
    ta[8] = 32'h0000_0003; tbv[8] = 32'd3;  tbf[8] = 4'b1011; texp[8] = 1'b0;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bf = '0; pred_taken = 1'b0;
    upd_idx = '0; stall = 1'b0; flush = 1'b0; lookup_idx = '0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    for (int i = 0; i < DEPTH; i++) look($sformatf("rst_pht%0d", i), i[IW-1:0], 1'b0);

    // beq taken, predicted not-taken; collision read sees the old counter
    issue(32'd5, 32'd5, 4'b1000, 1'b0, 6'd7);
    step();
    in_valid = 1'b0;
    check("beq_valid", {31'd0, res_valid}, 32'd1);
    check("beq_taken", {31'd0, taken}, 32'd1);
    check("beq_mp", {31'd0, mispredict}, 32'd1);
    look("beq_collision", 6'd7, 1'b0);
    step();
    look("beq_pht_after", 6'd7, 1'b1);
    check("beq_valid_drop", {31'd0, res_valid}, 32'd0);

    // unsigned vs signed less-than, issued back to back
    issue(32'hFFFF_FFFF, 32'd1, 4'b0100, 1'b0, 6'd10);
    step();
    check("bltu_taken", {31'd0, taken}, 32'd0);
    check("bltu_mp", {31'd0, mispredict}, 32'd0);
    issue(32'hFFFF_FFFF, 32'd1, 4'b0110, 1'b0, 6'd10);
    step();
    in_valid = 1'b0;
    check("blt_taken", {31'd0, taken}, 32'd1);
    check("blt_mp", {31'd0, mispredict}, 32'd1);
    step();

    for (int i = 0; i < 9; i++) begin
      issue(ta[i], tbv[i], tbf[i], 1'b0, 6'd20);
      step();
      check($sformatf("tbl%0d_taken", i), {31'd0, taken}, {31'd0, texp[i]});
      check($sformatf("tbl%0d_mp", i), {31'd0, mispredict}, {31'd0, texp[i]});
    end
    in_valid = 1'b0;
    step();

    // saturation at idx 3: 01 -> 11 (sat) then down to 00 (sat) and back to 01
    for (int i = 0; i < 4; i++) run_branch(32'd1, 32'd1, 4'b1000, 1'b1, 6'd3);
    look("sat_hi", 6'd3, 1'b1);
    run_branch(32'd1, 32'd2, 4'b1000, 1'b1, 6'd3);
    look("sat_hi_dec1", 6'd3, 1'b1);
    run_branch(32'd1, 32'd2, 4'b1000, 1'b1, 6'd3);
    look("sat_dec2", 6'd3, 1'b0);
    run_branch(32'd1, 32'd2, 4'b1000, 1'b1, 6'd3);
    run_branch(32'd1, 32'd2, 4'b1000, 1'b1, 6'd3);
    run_branch(32'd1, 32'd1, 4'b1000, 1'b1, 6'd3);
    look("sat_lo_inc", 6'd3, 1'b0);

    // stall holds the result; exactly one update on release
    issue(32'd4, 32'd4, 4'b1000, 1'b0, 6'd30);
    step();
    in_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_valid", i), {31'd0, res_valid}, 32'd1);
      check($sformatf("stall%0d_taken", i), {31'd0, taken}, 32'd1);
      check($sformatf("stall%0d_mp", i), {31'd0, mispredict}, 32'd1);
      look($sformatf("stall%0d_pht", i), 6'd30, 1'b0);
    end
    stall = 1'b0;
    step();
    look("stall_release_pht", 6'd30, 1'b1);
    run_branch(32'd4, 32'd5, 4'b1000, 1'b0, 6'd30);
    look("stall_single_upd", 6'd30, 1'b0);

    // flush together with stall kills the held result and the incoming one
    issue(32'd6, 32'd6, 4'b1000, 1'b0, 6'd40);
    step();
    stall = 1'b1; flush = 1'b1;
    issue(32'd6, 32'd6, 4'b1000, 1'b0, 6'd40);
    step();
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    check("flush_valid", {31'd0, res_valid}, 32'd0);
    check("flush_mp", {31'd0, mispredict}, 32'd0);
    step();
    check("flush_valid2", {31'd0, res_valid}, 32'd0);
    look("flush_no_upd", 6'd40, 1'b0);

    // non-branch code at idx 7 (counter 10): no decrement may happen
    issue(32'd5, 32'd5, 4'b0001, 1'b1, 6'd7);
    step();
    in_valid = 1'b0;
    check("nb_valid", {31'd0, res_valid}, 32'd1);
    check("nb_taken", {31'd0, taken}, 32'd0);
    check("nb_mp", {31'd0, mispredict}, 32'd0);
    step();
    look("nb_pht", 6'd7, 1'b1);

    // reset during stall overrides it
    issue(32'd5, 32'd5, 4'b1000, 1'b1, 6'd7);
    step();
    in_valid = 1'b0; stall = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; stall = 1'b0;
    check("rst_stall_valid", {31'd0, res_valid}, 32'd0);
    check("rst_stall_taken", {31'd0, taken}, 32'd0);
    look("rst_stall_pht", 6'd7, 1'b0);

`ifdef BCE_PRED_STATS_EN
    check("stats_rst_br", br_count, 32'd0);
    check("stats_rst_mp", mp_count, 32'd0);
    run_branch(32'd1, 32'd1, 4'b1000, 1'b0, 6'd1);
    run_branch(32'd1, 32'd1, 4'b1010, 1'b1, 6'd2);
    run_branch(32'd1, 32'd1, 4'b1000, 1'b1, 6'd4);
    run_branch(32'd1, 32'd1, 4'b0001, 1'b1, 6'd4);
    check("stats_br", br_count, 32'd3);
    check("stats_mp", mp_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
